sram_port_binder: RTL and testbench
===================================

// Module: sram_port_binder
// PURPOSE
//  Binds each write port's next packet to one SRAM bank of the shared buffer. Requesting ports are
//  chosen round-robin. The target SRAM is chosen from per-SRAM state: free_space, full and the
//  2-bit per-port prefer level. Each SRAM is locked to at most one writer at a time.
//  Sits between the port ingress FSMs and the NUM_SRAM sram_state/SRAM instances.
// PARAMETERS
//  NUM_PORTS  16    write ports
//  NUM_SRAM   32    SRAM banks
//  PW         4     port index width, clog2(NUM_PORTS)
//  SW         5     SRAM index width, clog2(NUM_SRAM)
//  LW         7     packet length width, in pages
// PORTS
//  clk          in   1                   system clock
//  rst_n        in   1                   async active-low reset
//  bind_req     in   NUM_PORTS           port p requests an SRAM; level, held until bind_gnt for p
//  bind_len     in   NUM_PORTS*LW        pages needed by port p's packet, slice [p*LW+:LW]
//  release      in   NUM_PORTS           1-cycle pulse: port p finished its packet, drop its binding
//  sram_free    in   NUM_SRAM*11         free_space of each SRAM, slice [s*11+:11]
//  sram_full    in   NUM_SRAM            full flag of each SRAM
//  sram_prefer  in   NUM_SRAM*NUM_PORTS*2  prefer level of SRAM s for port p, slice [(s*NUM_PORTS+p)*2+:2]
//  bind_gnt     out  1                   1-cycle pulse: binding issued
//  bind_port    out  PW                  granted port, valid with bind_gnt
//  bind_sram    out  SW                  granted SRAM, valid with bind_gnt
//  port_bound   out  NUM_PORTS           port p currently holds a binding
//  port_sram    out  NUM_PORTS*SW        SRAM bound to port p, valid while port_bound[p]
//  sram_lock    out  NUM_SRAM            SRAM s is bound to some port
// BEHAVIOUR
//  Reset (async): all outputs 0; rr_ptr=0; S0 valid flag=0; any in-flight request is discarded.
//  Stage S0 (cycle N):
//   - cand = bind_req & ~port_bound & ~(S0 valid ? onehot(p_q) : 0).
//   - Round-robin pick starting at rr_ptr, wrapping 15->0; register p_q and valid.
//   - rr_ptr <= picked+1 whether or not S1 later grants.
//  Stage S1 (cycle N+1): scan all SRAMs for p_q.
//   - eligible[s] = !sram_full[s] && !sram_lock[s] && sram_free[s] > bind_len[p_q] (11-bit unsigned compare).
//   - Winner: highest prefer level; tie -> larger free; tie -> lower index.
//   - If any eligible: at the N+2 edge set bind_gnt=1, bind_port=p_q, bind_sram=win;
//     set port_bound[p_q], port_sram[p_q]=win, sram_lock[win].
//   - No eligible SRAM: no grant; the request stays pending and is retried at its next RR turn.
//  Latency: request first seen at N -> bind_gnt visible in cycle N+2.
//  Throughput: one grant/cycle max, fully pipelined. A lock set by a grant is visible to the next S1 scan.
//  Release:
//   - release[p] with port_bound[p] clears port_bound[p] and sram_lock[port_sram[p]] at the next edge.
//   - release[p] with port_bound[p]=0 is ignored.
//   - Same-cycle release and S1 scan: the scan sees the pre-release lock, so the freed SRAM is usable
//     from the following cycle.
//  Same port, same cycle, release + bind_req: release is applied; the port is not a candidate until
//  the next cycle.
//  Same cycle, grant to port A on SRAM X + release of port B on SRAM Y: both applied; X != Y is
//  guaranteed by the lock.
//  bind_req dropped while in flight: the grant still issues, and the ingress FSM must release it.
// STRUCTURE
//  Package hydra_pkg:
//   - NUM_PORTS, NUM_SRAM, PW, SW, LW;
//   - typedef prefer_t (2b: 0 none, 1 <512, 2 <1536, 3 >=1536);
//   - typedef free_t (11b).
//  Sub-module sram_pick_tree:
//   - pipelined-free comparator tree over NUM_SRAM {eligible, prefer, free, index};
//   - outputs win index + any_eligible.
//  Top level holds the RR arbiter, S0/S1 registers and the binding/lock tables.
// TESTING
//  1. Reset, bind_req[3]=1, len=10; all SRAMs free=2047, prefer=0
//     -> gnt in cycle 2, port 3, SRAM 0; sram_lock=0x1.
//  2. bind_req=0xFFFF, all SRAMs empty, no release
//     -> 16 grants on consecutive cycles, ports 0..15 in order, SRAMs 0..15; no SRAM granted twice.
//  3. Port 5 request; SRAM 7 prefer[5]=3, SRAM 2 prefer[5]=1, SRAM 9 prefer[5]=3 with larger free
//     -> bind_sram=9.
//  4. Len=100; every unlocked SRAM has free<=100 or full=1 -> no gnt.
//     Then raise SRAM 4 free to 101 -> gnt on SRAM 4 within NUM_PORTS+2 cycles.
//  5. 31 SRAMs locked, port 0 bound to SRAM 31; release[0] while port 1 requests
//     -> SRAM 31 granted to port 1 no earlier than 2 cycles after release.
//  6. Assert rst_n=0 between S0 and S1 of a request -> no gnt, all tables 0.
//     After reset deasserts, the held request is granted 2 cycles later.

Source files
------------

// File: rtl/hydra_pkg.sv
`default_nettype none
// ============================================================================
// Package    : hydra_pkg
// Description: Shared sizes and types for the SRAM port binder.
// Revision   : 1.0 - initial release
// ============================================================================
package hydra_pkg;

    localparam int NUM_PORTS = 16;
    localparam int NUM_SRAM  = 32;
    localparam int PW        = 4;
    localparam int SW        = 5;
    localparam int LW        = 7;
    localparam int FW        = 11;

    // Prefer level: 0 none, 1 below 512, 2 below 1536, 3 at or above 1536.
    typedef logic [1:0]    prefer_t;
    typedef logic [FW-1:0] free_t;

    typedef struct packed {
        logic            elig;
        prefer_t         prefer;
        free_t           free;
        logic [SW-1:0]   idx;
    } cand_t;

    // a must come from the lower-index side, so ties fall through to a.
    function automatic cand_t cand_max(input cand_t a, input cand_t b);
        if (!b.elig) begin
            return a;
        end
        if (!a.elig) begin
            return b;
        end
        if (b.prefer > a.prefer) begin
            return b;
        end
        if ((b.prefer == a.prefer) && (b.free > a.free)) begin
            return b;
        end
        return a;
    endfunction

endpackage : hydra_pkg
`default_nettype wire

// File: rtl/sram_pick_tree.sv
`default_nettype none
// ============================================================================
// Module     : sram_pick_tree
// Description: Combinational comparator tree selecting the best eligible SRAM.
// Revision   : 1.0 - initial release
// ============================================================================
module sram_pick_tree
    import hydra_pkg::*;
(
    input  logic [NUM_SRAM-1:0]    i_elig,
    input  logic [NUM_SRAM*2-1:0]  i_prefer,
    input  logic [NUM_SRAM*FW-1:0] i_free,
    output logic [SW-1:0]          o_win,
    output logic                   o_any_elig
);

    // Heap layout: node n has children 2n+1 / 2n+2; leaves start at NUM_SRAM-1.
    // With a power-of-two NUM_SRAM the left child always covers lower indices.
    cand_t w_node [2*NUM_SRAM-1];

    always_comb begin
        for (int n = 0; n < 2*NUM_SRAM-1; n++) begin
            w_node[n] = '0;
        end
        for (int s = 0; s < NUM_SRAM; s++) begin
            w_node[NUM_SRAM-1+s] = '{elig:   i_elig[s],
                                     prefer: i_prefer[s*2 +: 2],
                                     free:   i_free[s*FW +: FW],
                                     idx:    SW'(s)};
        end
        for (int n = NUM_SRAM-2; n >= 0; n--) begin
            w_node[n] = cand_max(w_node[2*n+1], w_node[2*n+2]);
        end
    end

    assign o_win      = w_node[0].idx;
    assign o_any_elig = w_node[0].elig;

endmodule : sram_pick_tree
`default_nettype wire

// File: rtl/sram_port_binder.sv
`default_nettype none
// ============================================================================
// Module     : sram_port_binder
// Description: Round-robin port pick (S0) then best-SRAM bind (S1) with locks.
// Revision   : 1.0 - initial release
// ============================================================================
module sram_port_binder
    import hydra_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            bind_req,
    input  logic [NUM_PORTS*LW-1:0]         bind_len,
    input  logic [NUM_PORTS-1:0]            port_release,
    input  logic [NUM_SRAM*FW-1:0]          sram_free,
    input  logic [NUM_SRAM-1:0]             sram_full,
    input  logic [NUM_SRAM*NUM_PORTS*2-1:0] sram_prefer,
    output logic                            bind_gnt,
    output logic [PW-1:0]                   bind_port,
    output logic [SW-1:0]                   bind_sram,
    output logic [NUM_PORTS-1:0]            port_bound,
    output logic [NUM_PORTS*SW-1:0]         port_sram,
    output logic [NUM_SRAM-1:0]             sram_lock
);

    logic [PW-1:0]        rr_ptr_q,     rr_ptr_d;
    logic [PW-1:0]        p_q,          p_d;
    logic                 s0_valid_q,   s0_valid_d;
    logic                 bind_gnt_q,   bind_gnt_d;
    logic [PW-1:0]        bind_port_q,  bind_port_d;
    logic [SW-1:0]        bind_sram_q,  bind_sram_d;
    logic [NUM_PORTS-1:0] port_bound_q, port_bound_d;
    logic [NUM_SRAM-1:0]  sram_lock_q,  sram_lock_d;
    logic [SW-1:0]        port_sram_q [NUM_PORTS];
    logic [SW-1:0]        port_sram_d [NUM_PORTS];

    logic [NUM_PORTS-1:0] w_cand;
    logic [PW-1:0]        w_rr_idx;
    logic                 w_pick_found;
    logic [PW-1:0]        w_pick_port;

    logic [LW-1:0]        w_len;
    logic [NUM_SRAM-1:0]  w_elig;
    logic [NUM_SRAM*2-1:0] w_prefer;
    logic [SW-1:0]        w_win;
    logic                 w_any_elig;
    logic                 w_grant;

    // ---------------- S0: round-robin port pick ----------------
    always_comb begin
        w_cand = bind_req & ~port_bound_q;
        if (s0_valid_q) begin
            w_cand[p_q] = 1'b0;
        end
        w_pick_found = 1'b0;
        w_pick_port  = '0;
        w_rr_idx     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_rr_idx = rr_ptr_q + PW'(k);
            if (!w_pick_found && w_cand[w_rr_idx]) begin
                w_pick_found = 1'b1;
                w_pick_port  = w_rr_idx;
            end
        end
    end

    // ---------------- S1: SRAM eligibility for the staged port ----------------
    assign w_len = bind_len[p_q*LW +: LW];

    always_comb begin
        w_elig   = '0;
        w_prefer = '0;
        for (int s = 0; s < NUM_SRAM; s++) begin
            w_elig[s] = !sram_full[s] && !sram_lock_q[s] &&
                        (sram_free[s*FW +: FW] > free_t'(w_len));
            w_prefer[s*2 +: 2] = sram_prefer[(s*NUM_PORTS + int'(p_q))*2 +: 2];
        end
    end

    sram_pick_tree u_pick_tree (
        .i_elig     (w_elig),
        .i_prefer   (w_prefer),
        .i_free     (sram_free),
        .o_win      (w_win),
        .o_any_elig (w_any_elig)
    );

    assign w_grant = s0_valid_q && w_any_elig;

    // ---------------- Next state: pipeline and binding tables ----------------
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        p_d          = p_q;
        s0_valid_d   = w_pick_found;
        bind_gnt_d   = w_grant;
        bind_port_d  = bind_port_q;
        bind_sram_d  = bind_sram_q;
        port_bound_d = port_bound_q;
        sram_lock_d  = sram_lock_q;
        port_sram_d  = port_sram_q;

        if (w_pick_found) begin
            rr_ptr_d = w_pick_port + 1'b1;
            p_d      = w_pick_port;
        end

        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_release[p] && port_bound_q[p]) begin
                port_bound_d[p]             = 1'b0;
                sram_lock_d[port_sram_q[p]] = 1'b0;
            end
        end

        // The lock guarantees w_win differs from any SRAM freed above.
        if (w_grant) begin
            port_bound_d[p_q] = 1'b1;
            port_sram_d[p_q]  = w_win;
            sram_lock_d[w_win] = 1'b1;
            bind_port_d       = p_q;
            bind_sram_d       = w_win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            p_q          <= '0;
            s0_valid_q   <= 1'b0;
            bind_gnt_q   <= 1'b0;
            bind_port_q  <= '0;
            bind_sram_q  <= '0;
            port_bound_q <= '0;
            sram_lock_q  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                port_sram_q[p] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            p_q          <= p_d;
            s0_valid_q   <= s0_valid_d;
            bind_gnt_q   <= bind_gnt_d;
            bind_port_q  <= bind_port_d;
            bind_sram_q  <= bind_sram_d;
            port_bound_q <= port_bound_d;
            sram_lock_q  <= sram_lock_d;
            port_sram_q  <= port_sram_d;
        end
    end

    assign bind_gnt   = bind_gnt_q;
    assign bind_port  = bind_port_q;
    assign bind_sram  = bind_sram_q;
    assign port_bound = port_bound_q;
    assign sram_lock  = sram_lock_q;

    generate
        for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port_sram
            assign port_sram[gp*SW +: SW] = port_sram_q[gp];
        end
    endgenerate

endmodule : sram_port_binder
`default_nettype wire

// File: tb/tb_sram_port_binder.sv
`default_nettype none
// ============================================================================
// Module     : tb_sram_port_binder
// Description: Directed and random stimulus against a transaction-level model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_sram_port_binder;
    import hydra_pkg::*;

    logic                            clk = 1'b0;
    logic                            rst_n = 1'b0;
    logic [NUM_PORTS-1:0]            bind_req = '0;
    logic [NUM_PORTS*LW-1:0]         bind_len = '0;
    logic [NUM_PORTS-1:0]            port_release = '0;
    logic [NUM_SRAM*FW-1:0]          sram_free = '0;
    logic [NUM_SRAM-1:0]             sram_full = '0;
    logic [NUM_SRAM*NUM_PORTS*2-1:0] sram_prefer = '0;
    logic                            bind_gnt;
    logic [PW-1:0]                   bind_port;
    logic [SW-1:0]                   bind_sram;
    logic [NUM_PORTS-1:0]            port_bound;
    logic [NUM_PORTS*SW-1:0]         port_sram;
    logic [NUM_SRAM-1:0]             sram_lock;

    always #5 clk = ~clk;

    sram_port_binder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bind_req     (bind_req),
        .bind_len     (bind_len),
        .port_release (port_release),
        .sram_free    (sram_free),
        .sram_full    (sram_full),
        .sram_prefer  (sram_prefer),
        .bind_gnt     (bind_gnt),
        .bind_port    (bind_port),
        .bind_sram    (bind_sram),
        .port_bound   (port_bound),
        .port_sram    (port_sram),
        .sram_lock    (sram_lock)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: who holds what, which SRAMs are taken, and the one
    // port waiting between pick and scan.
    bit m_bound [NUM_PORTS];
    int m_sram  [NUM_PORTS];
    bit m_lock  [NUM_SRAM];
    int m_rr;
    bit m_v;
    int m_p;
    bit e_gnt;
    int e_port;
    int e_sram;
    bit n_pick_v;
    int n_pick_p;
    int n_best;
    bit n_rel   [NUM_PORTS];

    task automatic model_reset();
        for (int p = 0; p < NUM_PORTS; p++) begin
            m_bound[p] = 0;
            m_sram[p]  = 0;
        end
        for (int s = 0; s < NUM_SRAM; s++) m_lock[s] = 0;
        m_rr = 0; m_v = 0; m_p = 0; e_gnt = 0; e_port = 0; e_sram = 0;
    endtask

    task automatic model_eval();
        int bestkey;
        int key;
        int fr;
        n_best  = -1;
        bestkey = -1;
        if (m_v) begin
            for (int s = 0; s < NUM_SRAM; s++) begin
                fr = int'(sram_free[s*FW +: FW]);
                if (!sram_full[s] && !m_lock[s] && fr > int'(bind_len[m_p*LW +: LW])) begin
                    key = int'(sram_prefer[(s*NUM_PORTS + m_p)*2 +: 2]) * 4096 + fr;
                    if (key > bestkey) begin
                        bestkey = key;
                        n_best  = s;
                    end
                end
            end
        end
        n_pick_v = 0;
        n_pick_p = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            int q;
            q = (m_rr + k) % NUM_PORTS;
            if (!n_pick_v && bind_req[q] && !m_bound[q] && !(m_v && m_p == q)) begin
                n_pick_v = 1;
                n_pick_p = q;
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) n_rel[p] = port_release[p] && m_bound[p];
    endtask

    task automatic model_commit();
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (n_rel[p]) begin
                m_bound[p] = 0;
                m_lock[m_sram[p]] = 0;
            end
        end
        e_gnt = (n_best >= 0);
        if (e_gnt) begin
            e_port = m_p;
            e_sram = n_best;
            m_bound[m_p] = 1;
            m_sram[m_p]  = n_best;
            m_lock[n_best] = 1;
        end
        if (n_pick_v) begin
            m_rr = (n_pick_p + 1) % NUM_PORTS;
            m_p  = n_pick_p;
        end
        m_v = n_pick_v;
    endtask

    task automatic compare_all();
        logic [NUM_PORTS-1:0]    eb;
        logic [NUM_SRAM-1:0]     el;
        logic [NUM_PORTS*SW-1:0] es;
        logic [NUM_PORTS*SW-1:0] mask;
        eb = '0; el = '0; es = '0; mask = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            eb[p] = m_bound[p];
            if (m_bound[p]) begin
                es[p*SW +: SW]   = SW'(m_sram[p]);
                mask[p*SW +: SW] = '1;
            end
        end
        for (int s = 0; s < NUM_SRAM; s++) el[s] = m_lock[s];
        check("bind_gnt", bind_gnt, e_gnt);
        if (e_gnt) begin
            check("bind_port", bind_port, e_port);
            check("bind_sram", bind_sram, e_sram);
        end
        check("port_bound", port_bound, eb);
        check("sram_lock", sram_lock, el);
        check("port_sram", port_sram & mask, es);
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        model_commit();
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_gnt", bind_gnt, 0);
        check("rst_bound", port_bound, 0);
        check("rst_lock", sram_lock, 0);
        check("rst_psram", port_sram, 0);
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic env_uniform(input int fr);
        for (int s = 0; s < NUM_SRAM; s++) sram_free[s*FW +: FW] = FW'(fr);
        sram_full    = '0;
        sram_prefer  = '0;
        bind_req     = '0;
        port_release = '0;
    endtask

    initial begin
        bit got;
        int n;

        // 1: single request, latency and first SRAM
        env_uniform(2047);
        do_reset();
        check("rst_bind_port", bind_port, 0);
        check("rst_bind_sram", bind_sram, 0);
        bind_len[3*LW +: LW] = 7'd10;
        bind_req[3] = 1'b1;
        tick();
        check("t1_no_gnt_c1", bind_gnt, 0);
        tick();
        check("t1_gnt", bind_gnt, 1);
        check("t1_port", bind_port, 3);
        check("t1_sram", bind_sram, 0);
        check("t1_lock", sram_lock, 32'h1);
        bind_req = '0;

        // 2: every port requesting -> back-to-back grants in port order
        env_uniform(2047);
        do_reset();
        for (int p = 0; p < NUM_PORTS; p++) bind_len[p*LW +: LW] = LW'($urandom_range(0, 127));
        bind_req = '1;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (i >= 1 && i <= 16) begin
                check("t2_gnt", bind_gnt, 1);
                check("t2_port", bind_port, i - 1);
                check("t2_sram", bind_sram, i - 1);
            end
        end
        check("t2_idle", bind_gnt, 0);
        check("t2_locks", sram_lock, 32'h0000FFFF);
        bind_req = '0;

        // 3: prefer level then free space decide the winner
        env_uniform(1000);
        do_reset();
        sram_prefer[(7*NUM_PORTS + 5)*2 +: 2] = 2'd3;
        sram_prefer[(2*NUM_PORTS + 5)*2 +: 2] = 2'd1;
        sram_prefer[(9*NUM_PORTS + 5)*2 +: 2] = 2'd3;
        sram_free[9*FW +: FW] = 11'd1500;
        bind_len[5*LW +: LW] = 7'd10;
        bind_req[5] = 1'b1;
        tick();
        tick();
        check("t3_gnt", bind_gnt, 1);
        check("t3_sram", bind_sram, 9);
        bind_req = '0;

        // 4: nothing strictly larger than the length, then one SRAM becomes big enough
        env_uniform(0);
        do_reset();
        for (int s = 0; s < NUM_SRAM; s++) begin
            sram_free[s*FW +: FW] = FW'($urandom_range(0, 100));
            sram_full[s] = ($urandom_range(0, 3) == 0);
        end
        sram_free[4*FW +: FW] = 11'd100;
        sram_full[4] = 1'b0;
        bind_len[6*LW +: LW] = 7'd100;
        bind_req[6] = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bind_gnt) got = 1;
        end
        check("t4_no_grant", got, 0);
        sram_free[4*FW +: FW] = 11'd101;
        got = 0;
        for (int i = 0; i < NUM_PORTS + 2 && !got; i++) begin
            tick();
            if (bind_gnt) got = 1;
        end
        check("t4_gnt", got, 1);
        check("t4_sram", bind_sram, 4);
        bind_req = '0;

        // 5: the only free SRAM moves to a waiting port after release
        env_uniform(2047);
        do_reset();
        sram_full = 32'h7FFF_FFFF;
        bind_len[0*LW +: LW] = 7'd5;
        bind_req[0] = 1'b1;
        tick();
        tick();
        check("t5_first_sram", bind_sram, 31);
        bind_req[0] = 1'b0;
        bind_len[1*LW +: LW] = 7'd5;
        bind_req[1] = 1'b1;
        repeat (4) tick();
        port_release[0] = 1'b1;
        tick();
        check("t5_no_early", bind_gnt, 0);
        port_release = '0;
        got = 0;
        n = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            n++;
            if (bind_gnt) got = 1;
        end
        check("t5_gnt", got, 1);
        check("t5_port", bind_port, 1);
        check("t5_sram", bind_sram, 31);
        check("t5_latency_ok", n >= 2, 1);
        bind_req = '0;

        // 6: reset between pick and scan drops the in-flight request
        env_uniform(2047);
        do_reset();
        bind_len[2*LW +: LW] = 7'd9;
        bind_req[2] = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_gnt_rst", bind_gnt, 0);
        check("t6_bound_rst", port_bound, 0);
        check("t6_lock_rst", sram_lock, 0);
        model_reset();
        #2;
        rst_n = 1'b1;
        tick();
        check("t6_no_gnt", bind_gnt, 0);
        tick();
        check("t6_gnt", bind_gnt, 1);
        check("t6_port", bind_port, 2);
        check("t6_sram", bind_sram, 0);
        bind_req = '0;

        // Random traffic against the model
        env_uniform(0);
        do_reset();
        for (int s = 0; s < NUM_SRAM; s++) begin
            sram_free[s*FW +: FW] = FW'($urandom_range(0, 2047));
            sram_full[s] = ($urandom_range(0, 9) == 0);
        end
        for (int i = 0; i < NUM_SRAM * NUM_PORTS; i++) sram_prefer[i*2 +: 2] = 2'($urandom_range(0, 3));
        for (int c = 0; c < 1500; c++) begin
            port_release = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (m_bound[p] && $urandom_range(0, 7) == 0) port_release[p] = 1'b1;
                else if (!m_bound[p] && $urandom_range(0, 40) == 0) port_release[p] = 1'b1;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bind_req[p] && e_gnt && e_port == p) begin
                    bind_req[p] = 1'b0;
                end else if (!bind_req[p] && (!m_bound[p] || port_release[p]) &&
                             $urandom_range(0, 3) == 0) begin
                    bind_req[p] = 1'b1;
                    bind_len[p*LW +: LW] = LW'($urandom_range(0, 127));
                end
            end
            repeat (3) begin
                int s;
                s = $urandom_range(0, NUM_SRAM - 1);
                sram_free[s*FW +: FW] = FW'($urandom_range(0, 2047));
                sram_full[s] = ($urandom_range(0, 9) == 0);
            end
            repeat (4) begin
                int i;
                i = $urandom_range(0, NUM_SRAM * NUM_PORTS - 1);
                sram_prefer[i*2 +: 2] = 2'($urandom_range(0, 3));
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sram_port_binder
`default_nettype wire
